// File: rtl/animated_layer_rom_if.sv
// Bus bundle between the layer mixer (master) and the animated sprite layer
// memory (slave): runtime write port, pixel read port with a registered valid
// flag, and the animation sequencer controls and status.
interface animated_layer_rom_if #(
   parameter int X_LIMIT    = 240,
   parameter int Y_LIMIT    = 240,
   parameter int DATA_WIDTH = 4,
   parameter int FRAMES     = 4
);
   localparam int ADDR_W  = $clog2(X_LIMIT) + $clog2(Y_LIMIT);
   localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

   // write port
   logic                  WRITE_ROM;
   logic [FRAME_W-1:0]    WRITE_FRAME;
   logic [ADDR_W-1:0]     WRITE_ROM_ADDRESS;
   logic [DATA_WIDTH-1:0] WRITE_ROM_DATA;

   // read port
   logic                  ROM_READ;
   logic [ADDR_W-1:0]     ROM_ADDRESS;
   logic [DATA_WIDTH-1:0] ROM_DATA;
   logic                  ROM_VALID;

   // animation control and status
   logic                  FRAME_END;
   logic                  ANIM_ENABLE;
   logic [1:0]            ANIM_MODE;
   logic [7:0]            FRAME_HOLD;
   logic                  ANIM_RESTART;
   logic [FRAME_W-1:0]    CURRENT_FRAME;
   logic                  ANIM_DONE;

   modport master (
      output WRITE_ROM, WRITE_FRAME, WRITE_ROM_ADDRESS, WRITE_ROM_DATA,
      output ROM_READ, ROM_ADDRESS,
      output FRAME_END, ANIM_ENABLE, ANIM_MODE, FRAME_HOLD, ANIM_RESTART,
      input  ROM_DATA, ROM_VALID, CURRENT_FRAME, ANIM_DONE
   );

   modport slave (
      input  WRITE_ROM, WRITE_FRAME, WRITE_ROM_ADDRESS, WRITE_ROM_DATA,
      input  ROM_READ, ROM_ADDRESS,
      input  FRAME_END, ANIM_ENABLE, ANIM_MODE, FRAME_HOLD, ANIM_RESTART,
      output ROM_DATA, ROM_VALID, CURRENT_FRAME, ANIM_DONE
   );
endinterface

// File: rtl/animated_layer_rom.sv
// Multi-frame sprite layer memory. FRAMES images of X_LIMIT x Y_LIMIT pixels
// live in one block RAM (frame-major). A sequencer picks the displayed frame
// and only changes it on the mixer's end-of-scan pulse so a scan never tears.
// Reads take two cycles: RAM output register, then a registered data/valid
// stage that forces out-of-range pixels to transparent (0).
module animated_layer_rom #(
   parameter int    X_LIMIT    = 240,
   parameter int    Y_LIMIT    = 240,
   parameter int    DATA_WIDTH = 4,
   parameter int    FRAMES     = 4,
   parameter string INIT_FILE  = ""
) (
   input  logic                CLK,
   input  logic                RESET,
   animated_layer_rom_if.slave bus
);
   localparam int PIXEL_LIMIT = X_LIMIT * Y_LIMIT;
   localparam int ADDR_W      = $clog2(X_LIMIT) + $clog2(Y_LIMIT);
   localparam int FRAME_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1;
   localparam int DEPTH       = FRAMES * PIXEL_LIMIT;
   localparam int PHYS_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);
   localparam logic [FRAME_W-1:0] ZERO_FRAME = {FRAME_W{1'b0}};
   localparam logic [FRAME_W-1:0] ONE_FRAME  = FRAME_W'(1);

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_LOOP = 2'b01,
      MODE_PING = 2'b10,
      MODE_ONCE = 2'b11
   } anim_mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Frame-major physical address of a pixel.
   function automatic logic [PHYS_W-1:0] phys_addr(input logic [FRAME_W-1:0] frame,
                                                   input logic [ADDR_W-1:0]  pixel);
      phys_addr = PHYS_W'(frame) * PHYS_W'(PIXEL_LIMIT) + PHYS_W'(pixel);
   endfunction

   function automatic logic pixel_in_range(input logic [ADDR_W-1:0] pixel);
      pixel_in_range = ({1'b0, pixel} < (ADDR_W + 1)'(PIXEL_LIMIT));
   endfunction

   function automatic logic frame_in_range(input logic [FRAME_W-1:0] frame);
      frame_in_range = ({1'b0, frame} < (FRAME_W + 1)'(FRAMES));
   endfunction

   // memory and read pipeline
   logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] ram_q_r;
   logic                  rd_pend_r;
   logic                  rd_oob_r;
   logic [DATA_WIDTH-1:0] rom_data_r;
   logic                  rom_valid_r;

   logic                  rd_oob_s;
   logic [PHYS_W-1:0]     rd_index_s;
   logic                  wr_ok_s;
   logic [PHYS_W-1:0]     wr_index_s;

   // sequencer
   logic [FRAME_W-1:0]    frame_r,    frame_nxt_s;
   logic [7:0]            hold_cnt_r, hold_nxt_s;
   dir_e                  dir_r,      dir_nxt_s;
   logic                  done_r,     done_nxt_s;
   logic                  qualify_s;
   logic [FRAME_W-1:0]    target_s;

   // Decode read/write addresses; the read uses the frame displayed this cycle.
   always_comb begin
      rd_oob_s = ~pixel_in_range(bus.ROM_ADDRESS);
      if (rd_oob_s) begin
         rd_index_s = {PHYS_W{1'b0}};
      end else begin
         rd_index_s = phys_addr(frame_r, bus.ROM_ADDRESS);
      end
      wr_ok_s    = bus.WRITE_ROM & frame_in_range(bus.WRITE_FRAME)
                 & pixel_in_range(bus.WRITE_ROM_ADDRESS);
      wr_index_s = phys_addr(bus.WRITE_FRAME, bus.WRITE_ROM_ADDRESS);
   end

   // Block RAM with one write port and a registered read-first read port.
   always_ff @(posedge CLK) begin
      if (wr_ok_s) begin
         mem_r[wr_index_s] <= bus.WRITE_ROM_DATA;
      end
      ram_q_r <= mem_r[rd_index_s];
   end

   // Request tracking and registered output stage; reset drops in-flight reads.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rd_pend_r   <= 1'b0;
         rd_oob_r    <= 1'b0;
         rom_valid_r <= 1'b0;
         rom_data_r  <= {DATA_WIDTH{1'b0}};
      end else begin
         rd_pend_r   <= bus.ROM_READ;
         rd_oob_r    <= rd_oob_s;
         rom_valid_r <= rd_pend_r;
         rom_data_r  <= (rd_pend_r & ~rd_oob_r) ? ram_q_r : {DATA_WIDTH{1'b0}};
      end
   end

   // Sequencer state register.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         frame_r    <= ZERO_FRAME;
         hold_cnt_r <= 8'd0;
         dir_r      <= DIR_UP;
         done_r     <= 1'b0;
      end else begin
         frame_r    <= frame_nxt_s;
         hold_cnt_r <= hold_nxt_s;
         dir_r      <= dir_nxt_s;
         done_r     <= done_nxt_s;
      end
   end

   // Sequencer next state: restart wins, otherwise step on qualifying scan ends.
   always_comb begin
      frame_nxt_s = frame_r;
      hold_nxt_s  = hold_cnt_r;
      dir_nxt_s   = dir_r;
      done_nxt_s  = done_r;
      target_s    = frame_r;
      qualify_s   = bus.FRAME_END & bus.ANIM_ENABLE & (bus.ANIM_MODE != MODE_HOLD);

      if (bus.ANIM_RESTART) begin
         frame_nxt_s = ZERO_FRAME;
         hold_nxt_s  = 8'd0;
         dir_nxt_s   = DIR_UP;
         done_nxt_s  = 1'b0;
      end else begin
         // direction only means something in ping-pong; any other mode resets it
         if (bus.ANIM_MODE != MODE_PING) begin
            dir_nxt_s = DIR_UP;
         end else begin
            dir_nxt_s = dir_r;
         end

         if (qualify_s) begin
            // >= so a FRAME_HOLD lowered below the count advances right away
            if (hold_cnt_r >= bus.FRAME_HOLD) begin
               hold_nxt_s = 8'd0;
               case (bus.ANIM_MODE)
                  MODE_LOOP: begin
                     if (frame_r >= LAST_FRAME) begin
                        target_s = ZERO_FRAME;
                     end else begin
                        target_s = frame_r + ONE_FRAME;
                     end
                     frame_nxt_s = target_s;
                  end
                  MODE_PING: begin
                     if (LAST_FRAME == ZERO_FRAME) begin
                        target_s = ZERO_FRAME;
                     end else if (dir_r == DIR_UP) begin
                        if (frame_r >= LAST_FRAME) begin
                           target_s = LAST_FRAME - ONE_FRAME;
                        end else begin
                           target_s = frame_r + ONE_FRAME;
                        end
                     end else begin
                        if (frame_r == ZERO_FRAME) begin
                           target_s = ONE_FRAME;
                        end else begin
                           target_s = frame_r - ONE_FRAME;
                        end
                     end
                     // direction follows the motion and flips at either end
                     if (target_s == LAST_FRAME && LAST_FRAME != ZERO_FRAME) begin
                        dir_nxt_s = DIR_DOWN;
                     end else if (target_s == ZERO_FRAME) begin
                        dir_nxt_s = DIR_UP;
                     end else if (target_s < frame_r) begin
                        dir_nxt_s = DIR_DOWN;
                     end else begin
                        dir_nxt_s = DIR_UP;
                     end
                     frame_nxt_s = target_s;
                  end
                  MODE_ONCE: begin
                     if (frame_r >= LAST_FRAME) begin
                        target_s = LAST_FRAME;
                     end else begin
                        target_s = frame_r + ONE_FRAME;
                     end
                     if (target_s == LAST_FRAME) begin
                        done_nxt_s = 1'b1;
                     end else begin
                        done_nxt_s = done_r;
                     end
                     frame_nxt_s = target_s;
                  end
                  default: begin
                     frame_nxt_s = frame_r;
                  end
               endcase
            end else begin
               hold_nxt_s = hold_cnt_r + 8'd1;
            end
         end else begin
            hold_nxt_s = hold_cnt_r;
         end
      end
   end

   assign bus.ROM_DATA      = rom_data_r;
   assign bus.ROM_VALID     = rom_valid_r;
   assign bus.CURRENT_FRAME = frame_r;
   assign bus.ANIM_DONE     = done_r;

endmodule
